// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Front end of the n x n systolic multiply-accumulate array. It holds an
//   operand matrix A and a weight matrix W. On start it clears the array and
//   streams A into the west edge and W into the north edge with diagonal skew.
//   It then pulses ctl so the array captures its accumulators, and flags the
//   n-cycle window in which the east edge shifts the results out.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   wr_en/wr_sel  operand write strobe; wr_sel 0 = A, 1 = W (IDLE only)
//   wr_row/col    operand index
//   wr_data       operand word
//   start         single-cycle job start (IDLE only)
//   a_out         west-edge i_in, row r at [r*width +: width]
//   w_out         north-edge i_w, column c at [c*width +: width]
//   array_rst_n   one-cycle active-low clear of the PE array
//   ctl           PE ctl: 1 = load accumulator into o_out, 0 = shift
//   res_valid     east-edge o_out carries results
//   busy          job in progress
//   done          one-cycle completion pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepts operand writes and start
// CLEAR   | 1 cycle, array_rst_n low
// FEED    | 3n-2 cycles, skewed operands driven, counter t = 0..3n-3
// CAPTURE | 1 cycle, ctl high, array loads accumulators into o_out
// SHIFT   | n cycles, results shift out of the east edge
// DONE    | 1 cycle, done pulse

module systolic_feeder #(
   parameter int width = 8,
   parameter int n     = 4,
   parameter int aw    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_sel,
   input  logic [aw-1:0]      wr_row,
   input  logic [aw-1:0]      wr_col,
   input  logic [width-1:0]   wr_data,
   input  logic               start,
   output logic [n*width-1:0] a_out,
   output logic [n*width-1:0] w_out,
   output logic               array_rst_n,
   output logic               ctl,
   output logic               res_valid,
   output logic               busy,
   output logic               done
);

   localparam int cw         = $clog2(3*n - 2);
   localparam int feed_last  = 3*n - 3;
   localparam int shift_last = n - 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      FEED    = 3'd2,
      CAPTURE = 3'd3,
      SHIFT   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [cw-1:0]   cnt_q, cnt_d;

   // Operand storage is deliberately left out of reset so a reset does not
   // force software to reload both matrices.
   logic [width-1:0] a_mem [n][n];
   logic [width-1:0] w_mem [n][n];

   always_ff @(posedge clk) begin
      if (wr_en && (state_q == IDLE)) begin
         if (wr_sel) w_mem[wr_row][wr_col] <= wr_data;
         else        a_mem[wr_row][wr_col] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            state_d = FEED;
            cnt_d   = '0;
         end
         FEED: begin
            if (cnt_q == cw'(feed_last)) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cw'(1);
            end
         end
         CAPTURE: begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: begin
            if (cnt_q == cw'(shift_last)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cw'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Skewed feed: row r sees A[r][t-r] and column c sees W[t-c][c]; anything
   // outside the matrix is driven as zero so the array never accumulates
   // stray products before or after the useful diagonal.
   logic [cw-1:0] k_a, k_w;

   always_comb begin
      a_out       = '0;
      w_out       = '0;
      array_rst_n = 1'b1;
      ctl         = 1'b0;
      res_valid   = 1'b0;
      busy        = (state_q != IDLE);
      done        = 1'b0;
      k_a         = '0;
      k_w         = '0;
      unique case (state_q)
         CLEAR:   array_rst_n = 1'b0;
         FEED: begin
            for (int r = 0; r < n; r++) begin
               k_a = cnt_q - cw'(r);
               if ((cnt_q >= cw'(r)) && (k_a < cw'(n)))
                  a_out[r*width +: width] = a_mem[r][k_a[aw-1:0]];
            end
            for (int c = 0; c < n; c++) begin
               k_w = cnt_q - cw'(c);
               if ((cnt_q >= cw'(c)) && (k_w < cw'(n)))
                  w_out[c*width +: width] = w_mem[k_w[aw-1:0]][c];
            end
         end
         CAPTURE: ctl       = 1'b1;
         SHIFT:   res_valid = 1'b1;
         DONE:    done      = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int AW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic             wr_sel;
   logic [AW-1:0]    wr_row;
   logic [AW-1:0]    wr_col;
   logic [W-1:0]     wr_data;
   logic             start;
   logic [N*W-1:0]   a_out;
   logic [N*W-1:0]   w_out;
   logic             array_rst_n;
   logic             ctl;
   logic             res_valid;
   logic             busy;
   logic             done;

   int n_pass  = 0;
   int n_total = 0;

   systolic_feeder #(.width(W), .n(N), .aw(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .wr_data     (wr_data),
      .start       (start),
      .a_out       (a_out),
      .w_out       (w_out),
      .array_rst_n (array_rst_n),
      .ctl         (ctl),
      .res_valid   (res_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Bench copy of the operands and the expected products (Q4.4).
   logic [7:0] ma [N][N];
   logic [7:0] mw [N][N];
   int         exp_c [N][N];

   // PE-array model: inputs sampled mid-cycle, applied at the next rising edge.
   logic [N*W-1:0] s_a = '0;
   logic [N*W-1:0] s_w = '0;
   logic           s_ctl = 1'b0;
   logic           s_rstn = 1'b1;
   int acc [N][N];
   int ar  [N][N];
   int wr  [N][N];
   int oo  [N][N];

   always @(negedge clk) begin
      s_a    <= a_out;
      s_w    <= w_out;
      s_ctl  <= ctl;
      s_rstn <= array_rst_n;
   end

   always @(posedge clk) begin : pe_model
      int ain;
      int win;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (c == 0) ain = int'(s_a[r*W +: W]);
            else        ain = ar[r][c-1];
            if (r == 0) win = int'(s_w[c*W +: W]);
            else        win = wr[r-1][c];
            if (!s_rstn) begin
               acc[r][c] <= 0;
               ar[r][c]  <= 0;
               wr[r][c]  <= 0;
               oo[r][c]  <= 0;
            end else begin
               acc[r][c] <= acc[r][c] + ((ain * win) >> 4);
               ar[r][c]  <= ain;
               wr[r][c]  <= win;
               if (s_ctl)       oo[r][c] <= acc[r][c];
               else if (c == 0) oo[r][c] <= 0;
               else             oo[r][c] <= oo[r][c-1];
            end
         end
      end
   end

   task automatic compute_exp();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            exp_c[r][c] = 0;
            for (int k = 0; k < N; k++)
               exp_c[r][c] += (int'(ma[r][k]) * int'(mw[k][c])) >> 4;
         end
   endtask

   task automatic write_op(input logic sel, input int row, input int col, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = AW'(row);
      wr_col  = AW'(col);
      wr_data = data;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic load_mats();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            write_op(1'b0, r, c, ma[r][c]);
            write_op(1'b1, r, c, mw[r][c]);
         end
   endtask

   // Runs one job from IDLE; cycle 0 is the CLEAR cycle. inject >= 0 drives
   // start plus a W[0][0] <= 0x7F write during that cycle, both to be ignored.
   task automatic run_job(input string tag, input int inject);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc <= 17; cyc++) begin
         if (cyc == 0) begin
            n_total++;
            if ({array_rst_n, busy, ctl} !== 3'b010)
               $display("FAIL %s clear_cycle: {rst_n,busy,ctl} got %b want 010", tag, {array_rst_n, busy, ctl});
            else n_pass++;
         end
         if (cyc == 10) begin
            n_total++;
            if ({array_rst_n, ctl, res_valid, busy} !== 4'b1001)
               $display("FAIL %s feed_end: {rst_n,ctl,res_valid,busy} got %b want 1001", tag, {array_rst_n, ctl, res_valid, busy});
            else n_pass++;
         end
         if (cyc == 11) begin
            n_total++;
            if ({ctl, res_valid, a_out, w_out} !== {2'b10, {(2*N*W){1'b0}}})
               $display("FAIL %s capture: ctl=%b res_valid=%b a_out=%h w_out=%h want ctl=1 res_valid=0 zeros", tag, ctl, res_valid, a_out, w_out);
            else n_pass++;
         end
         if (cyc >= 12 && cyc <= 15) begin
            n_total++;
            if ({res_valid, ctl} !== 2'b10)
               $display("FAIL %s shift_flags s=%0d: {res_valid,ctl} got %b want 10", tag, cyc - 12, {res_valid, ctl});
            else n_pass++;
            for (int r = 0; r < N; r++) begin
               n_total++;
               if (oo[r][N-1][7:0] !== exp_c[r][N-1-(cyc-12)][7:0])
                  $display("FAIL %s east row%0d s=%0d: got %h want %h", tag, r, cyc - 12, oo[r][N-1][7:0], exp_c[r][N-1-(cyc-12)][7:0]);
               else n_pass++;
            end
         end
         if (cyc == 16) begin
            n_total++;
            if ({done, busy, res_valid} !== 3'b110)
               $display("FAIL %s done_cycle: {done,busy,res_valid} got %b want 110", tag, {done, busy, res_valid});
            else n_pass++;
         end
         if (cyc == 17) begin
            n_total++;
            if ({done, busy} !== 2'b00)
               $display("FAIL %s after_done: {done,busy} got %b want 00", tag, {done, busy});
            else n_pass++;
         end
         start = 1'b0;
         wr_en = 1'b0;
         if (cyc == inject) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_row  = '0;
            wr_col  = '0;
            wr_data = 8'h7F;
         end
         if (cyc < 17) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if ({a_out, w_out} !== '0)
            $display("FAIL reset_data cyc%0d: a_out=%h w_out=%h want 0", i, a_out, w_out);
         else n_pass++;
         n_total++;
         if ({ctl, res_valid, busy, done, array_rst_n} !== 5'b00001)
            $display("FAIL reset_ctrl cyc%0d: {ctl,res_valid,busy,done,rst_n} got %b want 00001", i, {ctl, res_valid, busy, done, array_rst_n});
         else n_pass++;
      end
   endtask

   task automatic test_skew();
      logic [N*W-1:0] ea [int];
      logic [N*W-1:0] ew [int];
      ea[1]  = 32'h00000000; ew[1]  = 32'h00000008;
      ea[2]  = 32'h00001001; ew[2]  = 32'h00000918;
      ea[4]  = 32'h30211203; ew[4]  = 32'h0B1A2938;
      ea[7]  = 32'h33000000; ew[7]  = 32'h3B000000;
      ea[10] = 32'h00000000; ew[10] = 32'h00000000;
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) begin
            ma[r][k] = 8'(16*r + k);
            mw[r][k] = 8'(16*r + k + 8);
         end
      load_mats();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc <= 17; cyc++) begin
         if (ea.exists(cyc)) begin
            n_total++;
            if (a_out !== ea[cyc])
               $display("FAIL skew_a t=%0d: got %h want %h", cyc - 1, a_out, ea[cyc]);
            else n_pass++;
            n_total++;
            if (w_out !== ew[cyc])
               $display("FAIL skew_w t=%0d: got %h want %h", cyc - 1, w_out, ew[cyc]);
            else n_pass++;
         end
         if (cyc == 16) begin
            n_total++;
            if (done !== 1'b1)
               $display("FAIL skew_done: got %b want 1", done);
            else n_pass++;
         end
         if (cyc < 17) @(negedge clk);
      end
   endtask

   task automatic set_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? 8'h10 : 8'h00;
            mw[r][c] = 8'h08;
         end
   endtask

   task automatic test_full_job();
      set_identity();
      load_mats();
      compute_exp();
      run_job("full", -1);
   endtask

   task automatic test_busy_ignore();
      run_job("busy_inject", 3);
      run_job("busy_after", -1);
   endtask

   task automatic test_write_with_start();
      mw[0][0] = 8'h20;
      compute_exp();
      wr_en   = 1'b1;
      wr_sel  = 1'b1;
      wr_row  = '0;
      wr_col  = '0;
      wr_data = 8'h20;
      run_job("wr_start", -1);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      n_total++;
      if (busy !== 1'b1)
         $display("FAIL midrst_pre: busy got %b want 1", busy);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if ({busy, ctl, array_rst_n, a_out, w_out} !== {3'b001, {(2*N*W){1'b0}}})
         $display("FAIL midrst_post: busy=%b ctl=%b rst_n=%b a_out=%h w_out=%h want 0 0 1 zeros", busy, ctl, array_rst_n, a_out, w_out);
      else n_pass++;
      run_job("midrst_rerun", -1);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 8'(16 * ((r + c) % 3));
            mw[r][c] = 8'((r + 2*c + 1) & 15);
         end
      load_mats();
      compute_exp();
      run_job("b2b_first", -1);
      run_job("b2b_second", -1);
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_sel  = 1'b0;
      wr_row  = '0;
      wr_col  = '0;
      wr_data = '0;
      start   = 1'b0;
      @(negedge clk);
      test_reset();
      test_skew();
      test_full_job();
      test_busy_ignore();
      test_write_with_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
